// File: rtl/scan_sequencer.sv
// scan_sequencer: walks a slot index over an 8-bit mask with dwell/gap timing to drive a 3-to-8 decoder.
// Optional SCAN_SEQ_HOLD_EN adds a hold input that freezes the dwell counter while scanning.
module scan_sequencer #(
  parameter int DWELL = 4,
  parameter int GAP   = 1,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
`ifdef SCAN_SEQ_HOLD_EN
  input  logic       hold,
`endif
  input  logic [7:0] slot_mask,
  output logic [2:0] sel,
  output logic       enable,
  output logic       busy,
  output logic       sweep_done
);
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_GAP} state_t;
  localparam logic [CNT_W-1:0] DW_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] GP_LAST = CNT_W'(GAP - 1);
  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [2:0]       r_sel, w_sel, w_lo, w_hi;
  logic             r_en, w_en, r_busy, w_busy, r_done, w_done;
  logic [7:0]       w_above;
  logic             w_has_hi, w_adv, w_hold;
`ifdef SCAN_SEQ_HOLD_EN
  assign w_hold = hold;
`else
  assign w_hold = 1'b0;
`endif
  assign sel        = r_sel;
  assign enable     = r_en;
  assign busy       = r_busy;
  assign sweep_done = r_done;
  assign w_above    = slot_mask & (8'hFE << r_sel);
  // descending loop leaves the lowest set bit of each vector
  always_comb begin
    w_lo     = 3'd0;
    w_hi     = 3'd0;
    w_has_hi = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (slot_mask[i]) w_lo = 3'(i);
      if (w_above[i]) begin
        w_hi     = 3'(i);
        w_has_hi = 1'b1;
      end
    end
  end
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_sel   = r_sel;
    w_en    = r_en;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_adv   = 1'b0;
    if (r_state == S_IDLE) begin
      if (start && !stop && |slot_mask) begin
        w_state = S_SCAN;
        w_sel   = w_lo;
        w_en    = 1'b1;
        w_busy  = 1'b1;
        w_cnt   = '0;
      end
    end else if (stop) begin
      w_state = S_IDLE;
      w_en    = 1'b0;
      w_busy  = 1'b0;
      w_cnt   = '0;
    end else if (r_state == S_SCAN) begin
      if (!w_hold) begin
        if (r_cnt != DW_LAST) w_cnt = r_cnt + 1'b1;
        else if (GAP > 0) begin
          w_state = S_GAP;
          w_en    = 1'b0;
          w_cnt   = '0;
        end else w_adv = 1'b1;
      end
    end else if (r_cnt != GP_LAST) w_cnt = r_cnt + 1'b1;
    else w_adv = 1'b1;
    // mask and mode only matter here, at the slot boundary
    if (w_adv) begin
      w_cnt = '0;
      if (slot_mask == 8'h00 || (!w_has_hi && mode)) begin
        w_state = S_IDLE;
        w_en    = 1'b0;
        w_busy  = 1'b0;
        w_done  = slot_mask != 8'h00;
      end else begin
        w_state = S_SCAN;
        w_sel   = w_has_hi ? w_hi : w_lo;
        w_en    = 1'b1;
        w_done  = !w_has_hi;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sel   <= 3'd0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_sel   <= w_sel;
      r_en    <= w_en;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end
endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: directed plan scenarios plus random traffic checked against a slot-period model.
module tb_scan_sequencer;
  localparam int DWELL = 4;
  localparam int GAP   = 1;
`ifdef SCAN_SEQ_HOLD_EN
  localparam bit HAS_HOLD = 1'b1;
`else
  localparam bit HAS_HOLD = 1'b0;
`endif
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, mode = 1'b0, hold = 1'b0;
  logic [7:0] slot_mask = 8'h00;
  logic [2:0] sel;
  logic       enable, busy, sweep_done;
  int         n_cmp = 0, n_bad = 0;
  bit         m_act, m_done;
  logic [2:0] m_sel;
  int         m_p;

  scan_sequencer #(.DWELL(DWELL), .GAP(GAP), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
`ifdef SCAN_SEQ_HOLD_EN
    .hold(hold),
`endif
    .slot_mask(slot_mask), .sel(sel), .enable(enable), .busy(busy), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mreset();
    m_act = 1'b0; m_sel = 3'd0; m_p = 0; m_done = 1'b0;
  endtask

  // model: slot position m_p runs 0..DWELL+GAP-1; enable while m_p < DWELL
  task automatic step();
    int  nxt;
    bit  found;
    m_done = 1'b0;
    nxt    = 0;
    found  = 1'b0;
    if (!m_act) begin
      if (start && !stop && slot_mask != 8'h00) begin
        for (int k = 0; k < 8; k++) if (!found && slot_mask[k]) begin nxt = k; found = 1'b1; end
        m_act = 1'b1; m_p = 0; m_sel = 3'(nxt);
      end
    end else if (stop) begin
      m_act = 1'b0; m_p = 0;
    end else if (!(HAS_HOLD && hold && m_p < DWELL)) begin
      if (m_p < DWELL + GAP - 1) m_p++;
      else if (slot_mask == 8'h00) begin
        m_act = 1'b0; m_p = 0;
      end else begin
        for (int j = 1; j <= 8; j++) begin
          if (!found && slot_mask[(int'(m_sel) + j) % 8]) begin
            nxt = (int'(m_sel) + j) % 8; found = 1'b1;
          end
        end
        m_done = nxt <= int'(m_sel);
        m_p = 0;
        if (m_done && mode) m_act = 1'b0;
        else m_sel = 3'(nxt);
      end
    end
  endtask

  task automatic check_out();
    chk("sel", 32'(sel), 32'(m_sel));
    chk("enable", 32'(enable), 32'(m_act && m_p < DWELL));
    chk("busy", 32'(busy), 32'(m_act));
    chk("sweep_done", 32'(sweep_done), 32'(m_done));
  endtask

  task automatic cyc(input logic st, input logic sp, input logic md, input logic [7:0] mk, input logic hd);
    @(negedge clk);
    check_out();
    start = st; stop = sp; mode = md; slot_mask = mk; hold = hd;
    @(posedge clk);
    step();
    #1;
  endtask

  initial begin
    logic [7:0] mk;
    int         n_dut, n_mod;
    mk = 8'hFF;
    mreset();
    repeat (2) @(negedge clk);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    // continuous full sweep and wrap
    cyc(1, 0, 0, 8'hFF, 0);
    repeat (45) cyc(0, 0, 0, 8'hFF, 0);
    cyc(0, 1, 0, 8'hFF, 0);
    // single sweep over slots 2 and 5
    cyc(1, 0, 1, 8'h24, 0);
    n_dut = 0;
    for (int i = 0; i < 14; i++) begin
      cyc(0, 0, 1, 8'h24, 0);
      n_dut += int'(sweep_done);
    end
    chk("t2_done_count", 32'(n_dut), 1);
    chk("t2_sel", 32'(sel), 5);
    chk("t2_busy", 32'(busy), 0);
    chk("t2_enable", 32'(enable), 0);
    // empty mask, then single-slot mask
    cyc(1, 0, 0, 8'h00, 0);
    repeat (3) cyc(0, 0, 0, 8'h00, 0);
    chk("t3_busy", 32'(busy), 0);
    chk("t3_enable", 32'(enable), 0);
    cyc(1, 0, 0, 8'h80, 0);
    n_dut = 0; n_mod = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 8'h80, 0);
      n_dut += int'(sweep_done);
      n_mod += int'(m_done);
    end
    chk("t3_done_count", 32'(n_dut), 32'(n_mod));
    chk("t3_sel", 32'(sel), 7);
    cyc(0, 1, 0, 8'h80, 0);
    // stop and start together during slot 3
    cyc(1, 0, 0, 8'hFF, 0);
    for (int i = 0; i < 100; i++) begin
      if (m_act && m_sel == 3'd3 && m_p == 1) break;
      cyc(0, 0, 0, 8'hFF, 0);
    end
    chk("t4_reach_sel", 32'(sel), 3);
    cyc(1, 1, 0, 8'hFF, 0);
    chk("t4_sel", 32'(sel), 3);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_enable", 32'(enable), 0);
    chk("t4_done", 32'(sweep_done), 0);
    // asynchronous reset during the gap after slot 6
    cyc(1, 0, 0, 8'hFF, 0);
    for (int i = 0; i < 100; i++) begin
      if (m_act && m_sel == 3'd6 && m_p == DWELL) break;
      cyc(0, 0, 0, 8'hFF, 0);
    end
    chk("t5_gap_sel", 32'(sel), 6);
    chk("t5_gap_enable", 32'(enable), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_sel", 32'(sel), 0);
    chk("t5_rst_enable", 32'(enable), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    mreset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) cyc(0, 0, 0, 8'hFF, 0);
    chk("t5_idle_busy", 32'(busy), 0);
    // hold on slot 1
    cyc(1, 0, 0, 8'hFF, 0);
    for (int i = 0; i < 100; i++) begin
      if (m_act && m_sel == 3'd1 && m_p == 1) break;
      cyc(0, 0, 0, 8'hFF, 0);
    end
    repeat (10) cyc(0, 0, 0, 8'hFF, 1);
    repeat (15) cyc(0, 0, 0, 8'hFF, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(29) == 0) mk = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
      cyc($urandom_range(15) == 0, $urandom_range(59) == 0, 1'($urandom_range(1)), mk,
          $urandom_range(3) == 0);
    end
    @(negedge clk);
    check_out();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
Upstream driver for the 3-to-8 one-hot decoder stage. Walks a 3-bit slot index across an 8-slot mask, presenting each slot for a programmable dwell time. Inserts a blanking gap between slots. Its sel/enable outputs connect directly to the decoder's in/enable inputs to scan LED digits, rows or chip selects. Supports continuous and single-sweep modes, start/stop control and a sweep-complete pulse.

Parameters:
DWELL, 4, cycles enable is held high per slot (legal range 1 .. 2^CNT_W-1)
GAP, 1, blanking cycles with enable low between slots (0 = no gap)
CNT_W, 16, width of the internal dwell/gap counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  start pulse, sampled on clk
stop  input  1  stop pulse, sampled on clk
mode  input  1  0 = continuous scan, 1 = single sweep
slot_mask  input  8  bit i = 1 means slot i is visited
sel  output  3  slot index to decoder in[2:0]
enable  output  1  decoder enable
busy  output  1  high whenever state != IDLE
sweep_done  output  1  one-cycle pulse at completion of a sweep

Behaviour:
- One clock, clk. Reset rst_n is asynchronous and active-low. All outputs are registered.
- Reset values: state=IDLE, sel=0, enable=0, busy=0, sweep_done=0, counter=0.
- States: IDLE, SCAN, GAP.
- IDLE: enable=0; sel holds its last value.
  - start=1 with slot_mask!=0: next cycle enter SCAN with sel = lowest set mask bit, enable=1, busy=1.
  - start=1 with slot_mask==0: ignored; stays IDLE with no pulse.
- SCAN: enable=1 for exactly DWELL cycles (counter 0..DWELL-1). After the last cycle:
  - GAP>0: go to GAP.
  - GAP=0: advance directly.
- GAP: enable=0, sel held, for exactly GAP cycles, then advance.
- Advance:
  - slot_mask is sampled only at the advance point. Mask changes mid-slot do not affect the current slot.
  - Next sel = next set mask bit strictly above the current sel. If none exists, wrap to the lowest set bit.
  - A wrap (next index <= current index, including a single-bit mask) completes a sweep. sweep_done=1 in the cycle the new slot starts.
  - On a wrap in mode=1: go IDLE instead. enable=0, busy=0, sweep_done=1 in that same cycle, and sel keeps the last slot.
  - mode is sampled at the advance point.
- Mask all zero at advance: go IDLE, enable=0, no sweep_done.
- Per-slot period = DWELL+GAP cycles. Enable never overlaps two sel values: sel changes only in the same cycle enable rises, or while enable=0.
- stop=1 in SCAN/GAP: next cycle IDLE, enable=0, busy=0, counter cleared, no sweep_done.
- stop and start together: stop wins.
- start while busy: ignored.
- Reset asserted mid-scan: outputs take reset values immediately (asynchronously). After release the block waits in IDLE for start.

Optional Feature:
SCAN_SEQ_HOLD_EN:
- Defined: adds input port hold (1 bit, placed after mode).
  - In SCAN, while hold=1, the dwell counter freezes and enable stays 1 on the current sel.
  - hold has no effect in GAP or IDLE.
  - stop still overrides hold.
- Undefined: no hold port; the counter always runs.

Test Plan:
1. Continuous sweep. DWELL=4, GAP=1, mask=8'hFF, mode=0, start pulse.
   -> enable rises 1 cycle later with sel=0. Each sel 0..7 shows enable high 4 cycles then low 1 cycle. sel returns to 0 after 40 cycles with a one-cycle sweep_done, and scanning continues.
2. Single sweep. mask=8'h24, mode=1, start.
   -> sel=2 for 4 cycles, gap, sel=5 for 4 cycles, gap. Then busy=0, enable=0, sel=5, and sweep_done pulses exactly once.
3. Empty mask. mask=8'h00, start.
   -> busy, enable and sweep_done stay 0. Then mask=8'h80 and start -> sel=7 scanned repeatedly, with sweep_done after every slot.
4. Stop/start collision. Assert stop and start in the same cycle during SCAN of sel=3.
   -> next cycle IDLE, enable=0, busy=0, sel=3, no sweep_done.
5. Reset mid-operation. Drop rst_n during GAP of sel=6.
   -> sel=0, enable=0, busy=0 immediately, before the next clk edge. After release, no activity until start.
6. Hold (SCAN_SEQ_HOLD_EN defined). hold=1 for 10 cycles during SCAN of sel=1.
   -> enable stays high 4+10 cycles on sel=1, then the normal gap and sel=2.
